// File: rtl/com_output_streamer_if.sv
// Readout bus bundle: controller request, memory read port and host com stream outputs.
// master = streamer side, slave = controller/memory/host side.
interface com_output_streamer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] com_data_out;
    logic              output_write_start;
    logic              output_write_done;
    logic              busy;
    logic              stream_done;

    modport master (
        input  start, base_addr, word_count, mem_rdata,
        output mem_rd_en, mem_addr, com_data_out, output_write_start,
        output_write_done, busy, stream_done
    );

    modport slave (
        output start, base_addr, word_count, mem_rdata,
        input  mem_rd_en, mem_addr, com_data_out, output_write_start,
        output_write_done, busy, stream_done
    );
endinterface

// File: rtl/com_output_streamer.sv
// Streams word_count memory words to com_data_out, first word 2 cycles after start, no bubbles, no backpressure.
// STREAM_CHECKSUM_EN appends a DATA_W-bit wrap-around sum word carrying output_write_done.
module com_output_streamer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    com_output_streamer_if.master bus
);

`ifdef STREAM_CHECKSUM_EN
    localparam int EXTRA_WORDS = 1;
`else
    localparam int EXTRA_WORDS = 0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_left;
    logic [ADDR_W:0]   out_left;   // one bit wider so word_count plus checksum cannot overflow
    logic              last_word;
    logic [DATA_W-1:0] data_q;
    logic              wr_start_q;
    logic              wr_done_q;
    logic              stream_done_q;
`ifdef STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign last_word = (out_left == (ADDR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.word_count == '0) ? DONE : PRIME;
                end
            end
            PRIME: begin
                rd_en     = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                rd_en = (rd_left != '0);
                if (last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stream outputs are registered: a STREAM cycle presents its word after the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr       <= '0;
            rd_left       <= '0;
            out_left      <= '0;
            data_q        <= '0;
            wr_start_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            stream_done_q <= 1'b0;
`ifdef STREAM_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            wr_start_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            stream_done_q <= (state == DONE);
            if (rd_en) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rd_addr  <= bus.base_addr;
                        rd_left  <= bus.word_count - ADDR_W'(1);
                        out_left <= {1'b0, bus.word_count} + (ADDR_W+1)'(EXTRA_WORDS);
`ifdef STREAM_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        rd_left <= rd_left - ADDR_W'(1);
                    end
                    wr_start_q <= 1'b1;
                    wr_done_q  <= last_word;
                    out_left   <= out_left - (ADDR_W+1)'(1);
`ifdef STREAM_CHECKSUM_EN
                    if (last_word) begin
                        data_q <= csum;
                    end else begin
                        data_q <= bus.mem_rdata;
                        csum   <= csum + bus.mem_rdata;
                    end
`else
                    data_q <= bus.mem_rdata;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_rd_en          = rd_en;
    assign bus.mem_addr           = rd_addr;
    assign bus.com_data_out       = data_q;
    assign bus.output_write_start = wr_start_q;
    assign bus.output_write_done  = wr_done_q;
    assign bus.busy               = (state != IDLE);
    assign bus.stream_done        = stream_done_q;

endmodule

// File: doc/com_output_streamer.md
Name: com_output_streamer

Overview:
- On-chip transmitter for the host result-readout interface of `main`.
- When the core controller signals that computation has finished, the block reads a contiguous region of data memory and streams it one word per clock on com_data_out.
- Framing uses output_write_start / output_write_done; the host bench samples every posedge while start is high and stops after the word flagged by done.
- Sits between shared data memory (read port) and the top-level com outputs; mirror of the com_data_in loader path.

Parameters:
- DATA_W, 16, width of memory words and com_data_out
- ADDR_W, 16, width of memory address, base_addr and word_count

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request from controller to begin readout; honoured only in IDLE
- base_addr  input  ADDR_W  first memory address to stream; sampled with start
- word_count  input  ADDR_W  number of words to stream; sampled with start
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_W  memory read address
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_rd_en (1-cycle synchronous RAM)
- com_data_out  output  DATA_W  streamed word (registered)
- output_write_start  output  1  high while com_data_out carries a valid stream word
- output_write_done  output  1  high together with the final stream word only
- busy  output  1  high in any state other than IDLE
- stream_done  output  1  one-cycle pulse in the cycle after the final word

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all outputs 0; counters 0. rst has priority over all other inputs, including mid-stream: the stream is truncated and output_write_start drops to 0 at that edge with no done flag.
- States and transitions:
  - IDLE: start=1 with word_count>0 -> latch base/count -> PRIME. start=1 with word_count=0 -> DONE (no stream words, no output_write_start).
  - PRIME: mem_rd_en=1, mem_addr=base. -> STREAM.
  - STREAM: each cycle, register mem_rdata into com_data_out with output_write_start=1. While reads remain, issue the next read (mem_addr increments by 1 per cycle, wraps modulo 2^ADDR_W). On the last word, output_write_done=1. -> DONE.
  - DONE: output_write_start=0, output_write_done=0, stream_done=1 for this one cycle. -> IDLE.
- Latency:
  - start sampled at edge E0 -> mem_rd_en visible after E0.
  - First word plus output_write_start visible after E2.
  - Word i is visible after E(2+i).
  - Stream is contiguous: exactly word_count consecutive cycles, no bubbles.
- Read issue: mem_rd_en is high for exactly word_count cycles (PRIME plus the first word_count-1 STREAM cycles); no over-read past base+word_count-1.
- com_data_out holds its last value after the stream ends; it is only meaningful while output_write_start=1.
- start while busy=1 is ignored; base_addr and word_count changes mid-stream are ignored.
- word_count=1: a single word with start and done both high in the same cycle.

Optional Feature:
- Macro: STREAM_CHECKSUM_EN.
- Defined:
  - One extra word is appended after the data: the DATA_W-bit wrap-around sum of all streamed words.
  - output_write_done moves to the checksum word, and the stream length becomes word_count+1.
  - word_count=0 still produces no stream.
- Undefined: no checksum logic; the stream is exactly word_count words.

Test Plan:
- Memory[4..6]=10,20,30; start with base=4, count=3 -> after 2 cycles com_data_out=10,20,30 on consecutive cycles; start=1 for 3 cycles; done=1 only with 30; stream_done pulses the next cycle. With STREAM_CHECKSUM_EN: 10,20,30,60 with done on 60.
- count=1, base=0, mem[0]=0xBEEF -> a single cycle with start=1, done=1, data=0xBEEF; mem_rd_en high for exactly 1 cycle.
- count=0 -> no output_write_start; busy high for 1 cycle; stream_done pulses 1 cycle after start.
- base=0xFFFE, count=3 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000.
- Pulse start again during a 5-word stream -> ignored; exactly 5 words are output; a later start in IDLE begins a new stream.
- Assert rst during word 2 of 4 -> output_write_start=0, busy=0, mem_rd_en=0 after that edge; no done; next start streams normally. With STREAM_CHECKSUM_EN: mem 0xFFFF,0x0002 -> checksum 0x0001.
